reg_bank_master: RTL and testbench

// - Initiator for the register-bank bus (reg_in_bus_t: data[31:0], sel[2:0], mode[0:0]).
// - Accepts one operation per handshake: an optional write-back plus up to three operand reads (A, B, C).
// - Sequences the operation onto the shared bus one slot at a time and captures the bank's q.
// - Returns the read operands on a valid/ready response port.
// - Sits between the instruction decode/execute logic and the register bank.
// - Drives bus_oe into the bus tristate buffer so that other masters can share the bus.

---
 rtl/reg_bank_master.sv | 205 ++++++++++++++++++++
 tb/tb_reg_bank_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_master.sv
// Register-bank bus initiator: one write plus up to three operand reads per operation.
// Optional feature: define REG_BYPASS_EN to serve same-register reads from the write data.
package reg_bank_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  sel;
    logic        mode;
  } reg_in_bus_t;
endpackage

module reg_bank_master
  import reg_bank_pkg::*;
#(
  parameter int READ_LAT    = 1,
  parameter int WRITE_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_wr_en,
  input  logic [2:0]  op_wr_sel,
  input  logic [31:0] op_wr_data,
  input  logic [2:0]  op_rd_mask,
  input  logic [2:0]  op_sel_a,
  input  logic [2:0]  op_sel_b,
  input  logic [2:0]  op_sel_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_a,
  output logic [31:0] rsp_b,
  output logic [31:0] rsp_c,
  output reg_in_bus_t bus_out,
  output logic        bus_oe,
  input  logic [31:0] bank_q
);

  typedef enum logic [2:0] {IDLE, WR, RD_A, RD_B, RD_C, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_sel_q, wr_sel_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [2:0]  mask_q, mask_d;
  logic [2:0]  byp_q, byp_d;
  logic [2:0]  sel_a_q, sel_a_d, sel_b_q, sel_b_d, sel_c_q, sel_c_d;
  logic [31:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d, rsp_c_q, rsp_c_d;
  logic        hold_q, hold_d;
  logic [2:0]  byp;
  logic [2:0]  mask_eff;

  // First required slot strictly after 'cur' in the configured slot order.
  function automatic state_t next_slot(state_t cur, logic wr, logic [2:0] m);
    state_t nxt;
    nxt = RESP;
    if (WRITE_FIRST != 0) begin
      case (cur)
        IDLE:    nxt = wr ? WR : m[0] ? RD_A : m[1] ? RD_B : m[2] ? RD_C : RESP;
        WR:      nxt = m[0] ? RD_A : m[1] ? RD_B : m[2] ? RD_C : RESP;
        RD_A:    nxt = m[1] ? RD_B : m[2] ? RD_C : RESP;
        RD_B:    nxt = m[2] ? RD_C : RESP;
        default: nxt = RESP;
      endcase
    end else begin
      case (cur)
        IDLE:    nxt = m[0] ? RD_A : m[1] ? RD_B : m[2] ? RD_C : wr ? WR : RESP;
        RD_A:    nxt = m[1] ? RD_B : m[2] ? RD_C : wr ? WR : RESP;
        RD_B:    nxt = m[2] ? RD_C : wr ? WR : RESP;
        RD_C:    nxt = wr ? WR : RESP;
        default: nxt = RESP;
      endcase
    end
    return nxt;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = wr_en_q;
    wr_sel_d  = wr_sel_q;
    wr_data_d = wr_data_q;
    mask_d    = mask_q;
    byp_d     = byp_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    sel_c_d   = sel_c_q;
    rsp_a_d   = rsp_a_q;
    rsp_b_d   = rsp_b_q;
    rsp_c_d   = rsp_c_q;
    hold_d    = hold_q;
    op_ready  = 1'b0;
    rsp_valid = 1'b0;
    bus_out   = '0;
    bus_oe    = 1'b0;
    byp       = 3'b000;
`ifdef REG_BYPASS_EN
    if (WRITE_FIRST != 0 && op_wr_en) begin
      byp[0] = op_rd_mask[0] && (op_sel_a == op_wr_sel);
      byp[1] = op_rd_mask[1] && (op_sel_b == op_wr_sel);
      byp[2] = op_rd_mask[2] && (op_sel_c == op_wr_sel);
    end
`endif
    mask_eff = op_rd_mask & ~byp;

    case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          wr_en_d   = op_wr_en;
          wr_sel_d  = op_wr_sel;
          wr_data_d = op_wr_data;
          mask_d    = mask_eff;
          byp_d     = byp;
          sel_a_d   = op_sel_a;
          sel_b_d   = op_sel_b;
          sel_c_d   = op_sel_c;
          rsp_a_d   = '0;
          rsp_b_d   = '0;
          rsp_c_d   = '0;
          cnt_d     = '0;
          state_d   = next_slot(IDLE, op_wr_en, mask_eff);
          // An empty operation still takes one cycle before rsp_valid rises.
          hold_d    = !op_wr_en && (mask_eff == 3'b000);
        end
      end
      WR: begin
        bus_oe  = 1'b1;
        bus_out = '{data: wr_data_q, sel: wr_sel_q, mode: 1'b1};
        if (byp_q[0]) rsp_a_d = wr_data_q;
        if (byp_q[1]) rsp_b_d = wr_data_q;
        if (byp_q[2]) rsp_c_d = wr_data_q;
        cnt_d   = '0;
        state_d = next_slot(WR, wr_en_q, mask_q);
      end
      RD_A, RD_B, RD_C: begin
        bus_oe = 1'b1;
        case (state_q)
          RD_A:    bus_out.sel = sel_a_q;
          RD_B:    bus_out.sel = sel_b_q;
          default: bus_out.sel = sel_c_q;
        endcase
        if (cnt_q == 3'(READ_LAT)) begin
          case (state_q)
            RD_A:    rsp_a_d = bank_q;
            RD_B:    rsp_b_d = bank_q;
            default: rsp_c_d = bank_q;
          endcase
          cnt_d   = '0;
          state_d = next_slot(state_q, wr_en_q, mask_q);
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          rsp_valid = 1'b1;
          if (rsp_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
      mask_q    <= '0;
      byp_q     <= '0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      sel_c_q   <= '0;
      rsp_a_q   <= '0;
      rsp_b_q   <= '0;
      rsp_c_q   <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
      mask_q    <= mask_d;
      byp_q     <= byp_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      sel_c_q   <= sel_c_d;
      rsp_a_q   <= rsp_a_d;
      rsp_b_q   <= rsp_b_d;
      rsp_c_q   <= rsp_c_d;
      hold_q    <= hold_d;
    end
  end

  assign rsp_a = rsp_a_q;
  assign rsp_b = rsp_b_q;
  assign rsp_c = rsp_c_q;

endmodule

// File: tb/tb_reg_bank_master.sv
// Bench for reg_bank_master: a write-first instance and a read-first instance, each on a bank model.
module tb_reg_bank_master;
  import reg_bank_pkg::*;

  localparam int RL = 1;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic [2:0]  mask;
    logic [2:0]  sa, sb, sc;
    logic [31:0] ea, eb, ec;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, c;
    int          lat;
    int          oe;
    int          wr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        op_valid[2], op_ready[2], op_wr_en[2];
  logic [2:0]  op_wr_sel[2], op_rd_mask[2], op_sel_a[2], op_sel_b[2], op_sel_c[2];
  logic [31:0] op_wr_data[2];
  logic        rsp_valid[2], rsp_ready[2];
  logic [31:0] rsp_a[2], rsp_b[2], rsp_c[2];
  reg_in_bus_t bus_out[2];
  logic        bus_oe[2];
  logic [31:0] bank_q[2];

  logic [31:0] regs[2][8];
  logic [31:0] qp[2][RL];
  logic        bank_clr, pre_en;
  int          pre_inst;
  logic [2:0]  pre_sel;
  logic [31:0] pre_data;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb_q[$];
  reg_in_bus_t bus_seen[$];
  vec_t        vecs[8];

  reg_bank_master #(.READ_LAT(RL), .WRITE_FIRST(1)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid[0]), .op_ready(op_ready[0]),
    .op_wr_en(op_wr_en[0]), .op_wr_sel(op_wr_sel[0]), .op_wr_data(op_wr_data[0]),
    .op_rd_mask(op_rd_mask[0]), .op_sel_a(op_sel_a[0]), .op_sel_b(op_sel_b[0]),
    .op_sel_c(op_sel_c[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_a(rsp_a[0]), .rsp_b(rsp_b[0]), .rsp_c(rsp_c[0]), .bus_out(bus_out[0]),
    .bus_oe(bus_oe[0]), .bank_q(bank_q[0]));

  reg_bank_master #(.READ_LAT(RL), .WRITE_FIRST(0)) dut_wf0 (
    .clk(clk), .reset(reset), .op_valid(op_valid[1]), .op_ready(op_ready[1]),
    .op_wr_en(op_wr_en[1]), .op_wr_sel(op_wr_sel[1]), .op_wr_data(op_wr_data[1]),
    .op_rd_mask(op_rd_mask[1]), .op_sel_a(op_sel_a[1]), .op_sel_b(op_sel_b[1]),
    .op_sel_c(op_sel_c[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_a(rsp_a[1]), .rsp_b(rsp_b[1]), .rsp_c(rsp_c[1]), .bus_out(bus_out[1]),
    .bus_oe(bus_oe[1]), .bank_q(bank_q[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: write at the closing edge, q valid RL edges after sel.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bank_clr) begin
        for (int r = 0; r < 8; r++) regs[i][r] <= '0;
      end else if (pre_en && pre_inst == i) begin
        regs[i][pre_sel] <= pre_data;
      end else if (bus_oe[i] && bus_out[i].mode) begin
        regs[i][bus_out[i].sel] <= bus_out[i].data;
      end
      qp[i][0] <= regs[i][bus_out[i].sel];
      for (int k = 1; k < RL; k++) qp[i][k] <= qp[i][k-1];
    end
  end
  assign bank_q[0] = qp[0][RL-1];
  assign bank_q[1] = qp[1][RL-1];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t expect_of(input int inst, input vec_t v);
    exp_t e;
    int   n, byp;
    n   = int'(v.mask[0]) + int'(v.mask[1]) + int'(v.mask[2]);
    byp = 0;
`ifdef REG_BYPASS_EN
    if (inst == 0 && v.wr_en)
      byp = int'(v.mask[0] && v.sa == v.wr_sel) + int'(v.mask[1] && v.sb == v.wr_sel)
          + int'(v.mask[2] && v.sc == v.wr_sel);
`endif
    e.a   = v.ea;
    e.b   = v.eb;
    e.c   = v.ec;
    e.wr  = int'(v.wr_en);
    e.oe  = e.wr + (n - byp) * (RL + 1);
    e.lat = (e.oe < 1) ? 1 : e.oe;
    if (inst > 1) e.lat = -1;
    return e;
  endfunction

  task automatic preload(input int inst, input logic [2:0] sel, input logic [31:0] data);
    pre_inst = inst; pre_sel = sel; pre_data = data; pre_en = 1'b1;
    @(posedge clk); @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drive_op(input int inst, input vec_t v);
    op_wr_en[inst]   = v.wr_en;
    op_wr_sel[inst]  = v.wr_sel;
    op_wr_data[inst] = v.wr_data;
    op_rd_mask[inst] = v.mask;
    op_sel_a[inst]   = v.sa;
    op_sel_b[inst]   = v.sb;
    op_sel_c[inst]   = v.sc;
    op_valid[inst]   = 1'b1;
  endtask

  // Acceptance edge, then scramble the op fields so only latched values can be used.
  task automatic accept_op(input int inst, input vec_t v);
    @(posedge clk);
    sb_q.push_back(expect_of(inst, v));
    @(negedge clk);
    op_valid[inst]   = 1'b0;
    op_wr_en[inst]   = 1'($urandom);
    op_wr_sel[inst]  = 3'($urandom);
    op_wr_data[inst] = $urandom;
    op_rd_mask[inst] = 3'($urandom);
    op_sel_a[inst]   = 3'($urandom);
    op_sel_b[inst]   = 3'($urandom);
    op_sel_c[inst]   = 3'($urandom);
  endtask

  task automatic applyStimulus(input int inst, input vec_t v);
    check_val("op_ready_before_op", 32'(op_ready[inst]), 32'd1);
    drive_op(inst, v);
    accept_op(inst, v);
  endtask

  task automatic checkOutput(input int inst, input int hold);
    exp_t e;
    int   lat, oe_n, wr_n, dirty, unstable;
    bit   got;
    e = sb_q.pop_front();
    bus_seen.delete();
    lat = 0; oe_n = 0; wr_n = 0; dirty = 0; got = 1'b0; unstable = 0;
    for (int k = 0; k < 200; k++) begin
      if (rsp_valid[inst]) begin
        got = 1'b1;
        break;
      end
      if (bus_oe[inst]) begin
        oe_n++;
        bus_seen.push_back(bus_out[inst]);
        if (bus_out[inst].mode) wr_n++;
      end else if (bus_out[inst] != '0) begin
        dirty++;
      end
      @(posedge clk); lat++; @(negedge clk);
    end
    check_val("rsp_arrived", 32'(got), 32'd1);
    if (!got) return;
    check_val("latency", 32'(lat), 32'(e.lat));
    check_val("oe_cycles", 32'(oe_n), 32'(e.oe));
    check_val("wr_cycles", 32'(wr_n), 32'(e.wr));
    check_val("bus_idle_clean", 32'(dirty), 32'd0);
    check_val("rsp_a", rsp_a[inst], e.a);
    check_val("rsp_b", rsp_b[inst], e.b);
    check_val("rsp_c", rsp_c[inst], e.c);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      if (!rsp_valid[inst] || op_ready[inst] || rsp_a[inst] !== e.a || rsp_b[inst] !== e.b
          || rsp_c[inst] !== e.c || bus_oe[inst]) unstable++;
    end
    if (hold > 0) check_val("rsp_hold_stable", 32'(unstable), 32'd0);
    rsp_ready[inst] = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready[inst] = 1'b0;
    check_val("rsp_valid_after_hs", 32'(rsp_valid[inst]), 32'd0);
    check_val("op_ready_after_hs", 32'(op_ready[inst]), 32'd1);
  endtask

  initial begin
    vec_t v;
    int   bad, cnt, oe_cnt;

    vecs[0] = '{1'b1, 3'd3, 32'hDEADBEEF, 3'b000, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 3'd0, 32'h0, 3'b111, 3'd1, 3'd2, 3'd6, 32'd5, 32'd7, 32'd9};
    vecs[2] = '{1'b1, 3'd4, 32'h1234, 3'b001, 3'd4, 3'd0, 3'd0, 32'h1234, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 3'd0, 32'h0, 3'b010, 3'd0, 3'd3, 3'd0, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[4] = '{1'b1, 3'd5, 32'h55, 3'b101, 3'd5, 3'd0, 3'd5, 32'h55, 32'h0, 32'h55};
    vecs[5] = '{1'b0, 3'd0, 32'h0, 3'b110, 3'd0, 3'd1, 3'd1, 32'h0, 32'd5, 32'd5};
    vecs[6] = '{1'b0, 3'd0, 32'h0, 3'b000, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0};
    vecs[7] = '{1'b1, 3'd1, 32'h11, 3'b111, 3'd2, 3'd1, 3'd4, 32'd7, 32'h11, 32'h1234};

    reset = 1'b1; bank_clr = 1'b1; pre_en = 1'b0; pre_inst = 0; pre_sel = '0; pre_data = '0;
    for (int i = 0; i < 2; i++) begin
      op_valid[i] = 1'b0; op_wr_en[i] = 1'b0; op_wr_sel[i] = '0; op_wr_data[i] = '0;
      op_rd_mask[i] = '0; op_sel_a[i] = '0; op_sel_b[i] = '0; op_sel_c[i] = '0;
      rsp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    bank_clr = 1'b0;
    preload(0, 3'd1, 32'd5);
    preload(0, 3'd2, 32'd7);
    preload(0, 3'd6, 32'd9);
    preload(1, 3'd4, 32'hAA);
    for (int i = 0; i < 2; i++) begin
      check_val("rst_op_ready", 32'(op_ready[i]), 32'd1);
      check_val("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check_val("rst_rsp_a", rsp_a[i], 32'h0);
      check_val("rst_bus_oe", 32'(bus_oe[i]), 32'd0);
      check_val("rst_bus_zero", 32'(bus_out[i] != '0), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("[TB] table vectors on write-first instance");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, vecs[i]);
      checkOutput(0, 0);
      if (i == 0 && bus_seen.size() == 1) begin
        check_val("wr_bus_sel", 32'(bus_seen[0].sel), 32'd3);
        check_val("wr_bus_mode", 32'(bus_seen[0].mode), 32'd1);
        check_val("wr_bus_data", bus_seen[0].data, 32'hDEADBEEF);
      end
      if (i == 1) begin
        bad = 0;
        for (int j = 0; j < bus_seen.size(); j++) begin
          case (j / (RL + 1))
            0: if (bus_seen[j].sel != 3'd1) bad++;
            1: if (bus_seen[j].sel != 3'd2) bad++;
            default: if (bus_seen[j].sel != 3'd6) bad++;
          endcase
          if (bus_seen[j].mode || bus_seen[j].data != '0) bad++;
        end
        check_val("rd_sel_hold", 32'(bad), 32'd0);
      end
    end

    $display("[TB] response back-pressure with a queued op");
    v = '{1'b0, 3'd0, 32'h0, 3'b111, 3'd1, 3'd2, 3'd6, 32'h11, 32'd7, 32'd9};
    applyStimulus(0, v);
    v = '{1'b0, 3'd0, 32'h0, 3'b001, 3'd2, 3'd0, 3'd0, 32'd7, 32'h0, 32'h0};
    drive_op(0, v);
    checkOutput(0, 5);
    accept_op(0, v);
    check_val("op_ready_after_accept", 32'(op_ready[0]), 32'd0);
    checkOutput(0, 0);

    $display("[TB] read-first instance same-register ordering");
    v = '{1'b1, 3'd4, 32'hBB, 3'b001, 3'd4, 3'd0, 3'd0, 32'hAA, 32'h0, 32'h0};
    applyStimulus(1, v);
    checkOutput(1, 0);
    v = '{1'b0, 3'd0, 32'h0, 3'b001, 3'd4, 3'd0, 3'd0, 32'hBB, 32'h0, 32'h0};
    applyStimulus(1, v);
    checkOutput(1, 0);

    $display("[TB] reset in the second cycle of RD_B");
    v = '{1'b0, 3'd0, 32'h0, 3'b111, 3'd1, 3'd2, 3'd6, 32'h11, 32'd7, 32'd9};
    applyStimulus(0, v);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check_val("rd_b_sel", 32'(bus_out[0].sel), 32'd2);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check_val("mid_rst_op_ready", 32'(op_ready[0]), 32'd1);
    check_val("mid_rst_bus_oe", 32'(bus_oe[0]), 32'd0);
    check_val("mid_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check_val("mid_rst_rsp_b", rsp_b[0], 32'h0);
    sb_q.delete();
    cnt = 0; oe_cnt = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid[0]) cnt++;
      if (bus_oe[0]) oe_cnt++;
    end
    check_val("dropped_no_rsp", 32'(cnt), 32'd0);
    check_val("dropped_no_bus", 32'(oe_cnt), 32'd0);
    applyStimulus(0, v);
    checkOutput(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
